// File: rtl/rot_feed_queue.sv
// rot_feed_queue: command FIFO and registered result stage around an external
// 4-bit combinational right-rotator. Commands {word, amount} are queued. The
// head entry drives the rotator. The rotator output is captured into a
// back-pressurable result register at up to one result per cycle.
module rot_feed_queue #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_data,
    input  logic [1:0]    in_sel,
    output logic [3:0]    rot_q,
    output logic [1:0]    rot_sel,
    input  logic [3:0]    rot_shifted,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_data,
    output logic [1:0]    out_sel,
    output logic [CW-1:0] count
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Each entry is packed as {word, amount}.
    logic [5:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [3:0]    out_data_q, out_data_d;
    logic [1:0]    out_sel_q, out_sel_d;

    logic       push;
    logic       pop;
    logic       free;
    logic [5:0] head;

    // Handshake qualifiers and head-of-queue drive toward the rotator.
    always_comb begin
        in_ready = (count_q != FULL) & ~rst;
        push     = in_valid & in_ready;
        free     = ~out_valid_q | out_ready;
        // A command pushed this cycle is not yet counted, so it cannot pop in the same cycle.
        pop      = (count_q != '0) & free;
        head     = mem_q[rd_ptr_q];
        if (count_q != '0) begin
            rot_q   = head[5:2];
            rot_sel = head[1:0];
        end else begin
            rot_q   = '0;
            rot_sel = '0;
        end
    end

    // Next-state for pointers, occupancy and the result register.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = rot_shifted;
            out_sel_d   = head[1:0];
        end else if (out_ready) begin
            // The held result was taken downstream and nothing replaces it.
            out_valid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control and result state, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of block ordering.
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    // FIFO storage write on an accepted command.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; count and the pointers
        // define which entries are meaningful.
        if (push) begin
            mem_q[wr_ptr_q] <= {in_data, in_sel};
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign count     = count_q;

endmodule

// File: tb/tb_rot_feed_queue.sv
// Self-checking bench for rot_feed_queue. A behavioural rotator closes the loop
// from rot_q/rot_sel to rot_shifted. Expected results are queued when a command
// is accepted and compared when a result leaves the block.
module tb_rot_feed_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_data;
    logic [1:0]    in_sel;
    logic [3:0]    rot_q;
    logic [1:0]    rot_sel;
    logic [3:0]    rot_shifted;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_data;
    logic [1:0]    out_sel;
    logic [CW-1:0] count;

    int         errors = 0;
    int         checks = 0;
    logic [5:0] sb[$];   // expected {sel, rotated word}

    always #5 clk = ~clk;

    // The rotator stand-in: rotate right by rot_sel.
    assign rot_shifted = 4'({rot_q, rot_q} >> rot_sel);

    rot_feed_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .rot_q      (rot_q),
        .rot_sel    (rot_sel),
        .rot_shifted(rot_shifted),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .count      (count)
    );

    // Reference rotation: move the low bit to the top, sel times.
    function automatic logic [3:0] rotr(input logic [3:0] d, input logic [1:0] s);
        logic [3:0] r;
        r = d;
        for (int i = 0; i < int'(s); i++) r = {r[0], r[3:1]};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // With out_ready low, four pushes leave one result held and three queued.
    task automatic fill4();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            in_sel   = 2'($urandom);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            step();
        end
        check(tag, 32'(sb.size()), 32'd0);
        check({tag, "_ov"}, 32'(out_valid), 32'd0);
    endtask

    // Scoreboard: handshakes observed mid-cycle complete at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("result", 32'({out_sel, out_data}), 32'(sb.pop_front()));
            end
            if (in_valid && in_ready) sb.push_back({in_sel, rotr(in_data, in_sel)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int accepted;
        int exp_count;
        logic exp_ov;
        logic do_push, do_pop;

        // Reset with random inputs.
        rst       = 1'b1;
        in_valid  = 1'($urandom);
        in_data   = 4'($urandom);
        in_sel    = 2'($urandom);
        out_ready = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_in_ready", 32'(in_ready), 32'd0);
            if (i == 0) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_out_data", 32'(out_data), 32'd0);
                check("rst_out_sel", 32'(out_sel), 32'd0);
                check("rst_count", 32'(count), 32'd0);
                check("rst_rot_q", 32'(rot_q), 32'd0);
                check("rst_rot_sel", 32'(rot_sel), 32'd0);
            end
            in_valid  = 1'($urandom);
            in_data   = 4'($urandom);
            out_ready = 1'($urandom);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single command: 1011 rotated right by 1.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'b1011;
        in_sel    = 2'd1;
        step();
        in_valid = 1'b0;
        check("single_count", 32'(count), 32'd1);
        check("single_rot_q", 32'(rot_q), 32'hb);
        check("single_rot_sel", 32'(rot_sel), 32'd1);
        step();
        check("single_ov", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'hd);
        check("single_sel", 32'(out_sel), 32'd1);
        step();
        check("single_ov_clear", 32'(out_valid), 32'd0);

        // Backpressure: seven offered, five accepted, head result frozen.
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i * 3 + 2);
            in_sel   = 2'(i);
            if (in_ready) accepted++;
            step();
            if (i >= 1) begin
                check("bp_ov", 32'(out_valid), 32'd1);
                check("bp_stable", 32'({out_sel, out_data}), 32'(sb[0]));
            end
        end
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_count", 32'(count), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_ov", 32'(out_valid), 32'd1);
            step();
            if (i == 0) begin
                check("bp_in_ready_rise", 32'(in_ready), 32'd1);
                check("bp_count_after_pop", 32'(count), 32'd3);
            end
        end
        check("bp_drained_ov", 32'(out_valid), 32'd0);
        check("bp_drained_count", 32'(count), 32'd0);

        // Streaming: eight back-to-back commands, no bubbles.
        out_ready = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            if (k <= 8) begin
                in_valid = 1'b1;
                in_data  = 4'(k);
                in_sel   = 2'(k - 1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            check("stream_ov", 32'(out_valid), 32'(k >= 2 && k <= 9));
            check("stream_count_le1", 32'(count <= 1), 32'd1);
        end
        drain("stream_drain");

        // Simultaneous push/pop at count 3, then random operations.
        fill4();
        check("sim_fill_count", 32'(count), 32'd3);
        check("sim_fill_ov", 32'(out_valid), 32'd1);
        in_valid  = 1'b1;
        in_data   = 4'($urandom);
        in_sel    = 2'($urandom);
        out_ready = 1'b1;
        step();
        check("sim_count", 32'(count), 32'd3);
        exp_count = 3;
        exp_ov    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom);
            in_sel    = 2'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            check("rand_in_ready", 32'(in_ready), 32'(exp_count != DEPTH));
            do_push = in_valid && (exp_count != DEPTH);
            do_pop  = (exp_count != 0) && (!exp_ov || out_ready);
            step();
            exp_count = exp_count + int'(do_push) - int'(do_pop);
            exp_ov    = do_pop ? 1'b1 : (exp_ov & ~out_ready);
            check("rand_count", 32'(count), 32'(exp_count));
            check("rand_ov", 32'(out_valid), 32'(exp_ov));
        end
        drain("rand_drain");

        // Reset mid-operation discards everything.
        fill4();
        check("mid_fill_count", 32'(count), 32'd3);
        check("mid_fill_ov", 32'(out_valid), 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        sb.delete();
        step();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_ov", 32'(out_valid), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'b0110;
        in_sel   = 2'd2;
        step();
        in_valid = 1'b0;
        step();
        check("mid_ov", 32'(out_valid), 32'd1);
        check("mid_data", 32'(out_data), 32'h9);
        check("mid_sel", 32'(out_sel), 32'd2);
        step();
        check("mid_ov_clear", 32'(out_valid), 32'd0);
        check("mid_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rot_feed_queue.md
# rot_feed_queue

Command queue and result capture stage wrapped around the 4-bit combinational right-rotator. It accepts {word, rotate amount} commands over a valid/ready handshake and buffers them in a small FIFO. It drives the head command onto the rotator inputs, registers the rotator result, and presents it downstream over a second valid/ready handshake. This gives the purely combinational rotator a registered, back-pressurable pipeline at one result per cycle.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, width of `count` (derived, not overridden)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high, sampled on rising edge of clk
- in_valid  in  1  command present
- in_ready  out  1  queue can accept a command
- in_data  in  4  word to rotate
- in_sel  in  2  rotate-right amount, 0..3
- rot_q  out  4  to rotator data input
- rot_sel  out  2  to rotator select input
- rot_shifted  in  4  from rotator output; combinational function of rot_q/rot_sel
- out_valid  out  1  result register holds a result
- out_ready  in  1  downstream accepts the result
- out_data  out  4  rotated word
- out_sel  out  2  rotate amount that produced out_data
- count  out  CW  FIFO occupancy, 0..DEPTH; excludes the result register

## Operation
- FIFO: write pointer, read pointer and count are registers. Pointers wrap modulo DEPTH.
- Push: `push = in_valid & in_ready`. Writes {in_data, in_sel} at the write pointer, then increments the pointer.
- `in_ready = (count != DEPTH) & ~rst`.
- Head drive: when count > 0, rot_q/rot_sel equal the head entry. When count == 0, both are 0.
- Result register states:
  - EMPTY when out_valid = 0.
  - HOLD when out_valid = 1.
- `free = ~out_valid | out_ready`.
- Pop: `pop = (count != 0) & free`. On pop:
  - out_data <= rot_shifted
  - out_sel <= head sel
  - out_valid <= 1
  - read pointer increments
- Transitions:
  - EMPTY→HOLD on pop.
  - HOLD→HOLD on pop with out_ready = 1, back-to-back results.
  - HOLD→EMPTY when out_ready = 1 and count == 0.
  - HOLD→HOLD with all values frozen when out_ready = 0.
- Count update: +1 on push only; −1 on pop only; unchanged when both or neither occur.
- Simultaneous push and pop at count == DEPTH cannot occur, because in_ready is 0 when full.
- Simultaneous push and pop at count == 0 cannot occur: the pushed entry is not yet visible, so pop requires count != 0. The entry is captured no earlier than the next cycle.
- in_sel is taken as-is; all 4 values are legal. Rotation semantics belong to the rotator; this block only transports values.
- Output ordering is strictly FIFO.
- Downstream rule: while out_valid = 1 and out_ready = 0, out_data and out_sel do not change.

## Timing
- Reset (rst high at an edge) clears the following; FIFO contents are don't-care:
  - pointers = 0, count = 0
  - out_valid = 0, out_data = 0, out_sel = 0
- Reset consequences:
  - rot_q = 0 and rot_sel = 0 (empty queue).
  - in_ready = 0 while rst is high, 1 in the first cycle after rst deasserts.
- Reset mid-operation discards all queued and held results. No output handshake completes during a reset cycle.
- Latency: command accepted at edge N.
  - Appears on rot_q/rot_sel after edge N.
  - Captured at edge N+1 when free.
  - out_valid = 1 after edge N+1. Minimum input-to-output latency is 2 cycles.
- Throughput: 1 command/cycle sustained when out_ready is held 1.
- Combinational paths:
  - in_ready depends only on count and rst.
  - out_valid, out_data and out_sel are registered.
  - The only in→out combinational path is rot_q/rot_sel → rotator → rot_shifted → capture flops.
- Total buffering: DEPTH + 1 commands.

## Test plan
Bench connects rot_q/rot_sel to the existing rotator and feeds its output back to rot_shifted. Scoreboard model: rotate right by sel.
- Reset: hold rst 3 cycles with random inputs -> during reset in_ready = 0; after the first reset edge out_valid = 0, out_data = 0, out_sel = 0, count = 0, rot_q = 0; in_ready = 1 the cycle after rst falls.
- Single command: push in_data = 4'b1011, in_sel = 1 at edge N, out_ready = 1 -> out_valid = 1 after edge N+1, out_data = 4'b1101, out_sel = 1; out_valid = 0 after edge N+2.
- Backpressure/full: out_ready = 0, present 7 commands back-to-back (DEPTH = 4) -> exactly 5 accepted (1 in the result register, 4 queued), count = 4, in_ready = 0, out_data stable. Then out_ready = 1 -> 5 results in order, one per cycle, and in_ready rises the cycle after the first drain.
- Streaming: out_ready = 1, push 8 commands on consecutive cycles with data 4'h1..4'h8 and sel cycling 0,1,2,3 -> 8 consecutive out_valid cycles with no bubble, results matching the model, count ≤ 1 throughout.
- Simultaneous push/pop at count = 3: fill to 3 with out_ready = 1 and in_valid = 1 for the same cycle -> count stays 3, the popped result is correct, pointers wrap without corruption across 20 random operations.
- Reset mid-operation: with count = 3 and out_valid = 1, assert rst for 1 cycle -> after the edge count = 0 and out_valid = 0. The next pushed command (4'b0110, sel 2) produces out_data = 4'b1001 with no stale entries.
